// File: rtl/ps2_key_event_tracker_if.sv
// Purpose: bundles the PS/2 frame input, key bitmap and event-queue handshake of ps2_key_event_tracker.
// Latency: none, wires only.
// Backpressure: evt_valid/evt_ready handshake on the event side; the PS/2 side is a strobe with no stall.
// Ports: slave = tracker side (frame in, events out); master = producer/consumer side.
interface ps2_key_event_tracker_if #(
  parameter int NUM_KEYS   = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                ps2_ready;
  logic [9:0]          ps2_data_in;
  logic [NUM_KEYS-1:0] key_status;
  logic                evt_valid;
  logic                evt_ready;
  logic [IDX_W+1:0]    evt_data;
  logic [CNT_W-1:0]    evt_count;
  logic                overflow;
  logic                clear_overflow;

  modport slave (
    input  ps2_ready, ps2_data_in, evt_ready, clear_overflow,
    output key_status, evt_valid, evt_data, evt_count, overflow
  );

  modport master (
    output ps2_ready, ps2_data_in, evt_ready, clear_overflow,
    input  key_status, evt_valid, evt_data, evt_count, overflow
  );
endinterface

// File: rtl/ps2_key_event_tracker.sv
// Purpose: maps decoded PS/2 frames onto a key table, keeps a held-key bitmap, queues press/release/repeat events.
// Latency: key_status and pushed event visible 1 cycle after ps2_ready; event FIFO is first-word fall-through.
// Backpressure: evt_valid/evt_ready; when the FIFO is full and not popping, new events drop and set overflow.
// Ports: clk, reset (sync, active-high); bus.slave carries ps2_ready/ps2_data_in in, key_status,
//        evt_valid/evt_ready/evt_data/evt_count, overflow/clear_overflow.

// Generic synchronous FIFO: first-word fall-through head, reads as zero when empty.
module ps2_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  // A pop on an empty FIFO is a no-op; a full FIFO still takes a push when it pops the same cycle.
  assign pop_ok   = pop && (count != '0);
  assign push_ok  = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
  assign head_dat = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end
endmodule

module ps2_key_event_tracker #(
  parameter int NUM_KEYS = 32,
  // Index order: 0-25 A-Z, 26 up, 27 down, 28 left, 29 right (E0-extended), 30 space, 31 enter.
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {
    9'h05A, 9'h029, 9'h174, 9'h16B, 9'h172, 9'h175,
    9'h01A, 9'h035, 9'h022, 9'h01D, 9'h02A, 9'h03C, 9'h02C, 9'h01B, 9'h02D, 9'h015,
    9'h04D, 9'h044, 9'h031, 9'h03A, 9'h04B, 9'h042, 9'h03B, 9'h043, 9'h033, 9'h034,
    9'h02B, 9'h024, 9'h023, 9'h021, 9'h032, 9'h01C},
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_key_event_tracker_if.slave  bus
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [31:0] RD_LAST = (REPEAT_DELAY > 0) ? 32'(REPEAT_DELAY - 1) : 32'd0;
  localparam logic [31:0] RP_LAST = (REPEAT_PERIOD > 0) ? 32'(REPEAT_PERIOD - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_PEND} rpt_state_t;

  rpt_state_t          state, state_nx;
  logic [31:0]         cnt, cnt_nx;
  logic [IDX_W-1:0]    rpt_key, rpt_key_nx, pend_key, pend_key_nx;
  logic                ret_delay, ret_nx;
  logic [NUM_KEYS-1:0] key_q;
  logic                hit, held, ps_make, ps_break, ps_push, brk_rpt, due, rpt_push;
  logic [IDX_W-1:0]    hit_idx;
  logic                fifo_push, fifo_push_ok;
  logic [IDX_W+1:0]    fifo_dat;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == {bus.ps2_data_in[9], bus.ps2_data_in[7:0]}) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign held     = key_q[hit_idx];
  assign ps_make  = bus.ps2_ready && hit && !bus.ps2_data_in[8] && !held;
  assign ps_break = bus.ps2_ready && hit &&  bus.ps2_data_in[8] &&  held;
  assign ps_push  = ps_make || ps_break;
  assign brk_rpt  = ps_break && (hit_idx == rpt_key) && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) key_q <= '0;
    else if (ps_make)  key_q[hit_idx] <= 1'b1;
    else if (ps_break) key_q[hit_idx] <= 1'b0;
  end

  // Repeat FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rpt_key   <= '0;
      pend_key  <= '0;
      ret_delay <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rpt_key   <= rpt_key_nx;
      pend_key  <= pend_key_nx;
      ret_delay <= ret_nx;
    end
  end

  // Repeat FSM: next state. PEND keeps counting so the repeat cadence is not stretched by
  // a write-port collision; ret_delay remembers whether a new press is timing its first delay.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rpt_key_nx  = rpt_key;
    pend_key_nx = pend_key;
    ret_nx      = ret_delay;
    if (REPEAT_DELAY == 0) begin
      state_nx = S_IDLE;
    end else if (ps_make) begin
      rpt_key_nx = hit_idx;
      cnt_nx     = '0;
      if (due || state == S_PEND) begin
        // The old key's repeat is still owed one slot; the new key then starts its delay.
        state_nx = S_PEND;
        ret_nx   = 1'b1;
        if (state != S_PEND) pend_key_nx = rpt_key;
      end else begin
        state_nx = S_DELAY;
      end
    end else if (brk_rpt) begin
      state_nx = S_IDLE;
    end else if (state == S_PEND) begin
      cnt_nx = cnt + 32'd1;
      if (!ps_push) state_nx = ret_delay ? S_DELAY : S_REPEAT;
    end else if (due) begin
      cnt_nx = '0;
      if (ps_push) begin
        state_nx    = S_PEND;
        pend_key_nx = rpt_key;
        ret_nx      = 1'b0;
      end else begin
        state_nx = S_REPEAT;
      end
    end else if (state != S_IDLE) begin
      cnt_nx = cnt + 32'd1;
    end
  end

  // Repeat FSM: outputs. A PS/2 event always owns the single write port.
  always_comb begin
    due      = ((state == S_DELAY) && (cnt >= RD_LAST)) ||
               ((state == S_REPEAT) && (cnt >= RP_LAST));
    rpt_push = !ps_push && (due || (state == S_PEND));
  end

  assign fifo_push = ps_push || rpt_push;
  assign fifo_dat  = ps_push ? {1'b0, bus.ps2_data_in[8], hit_idx}
                             : {2'b10, (state == S_PEND) ? pend_key : rpt_key};

  ps2_evt_fifo #(.W(IDX_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (fifo_dat),
    .pop      (bus.evt_ready),
    .head_dat (bus.evt_data),
    .count    (bus.evt_count),
    .push_ok  (fifo_push_ok)
  );

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) bus.overflow <= 1'b0;
    else if (fifo_push && !fifo_push_ok) bus.overflow <= 1'b1;
    else if (bus.clear_overflow) bus.overflow <= 1'b0;
  end

  assign bus.key_status = key_q;
  assign bus.evt_valid  = (bus.evt_count != '0);
endmodule
